// File: rtl/switch_port_tx.sv
// Egress transmitter: drains pointer/data FIFOs into a sof/dv/byte stream with IFG, length filter and counters.
// Latency: ptr read at t, first byte on dout at t+3; no backpressure, reads data FIFO blindly for len cycles.
module switch_port_tx #(
  parameter int IFG     = 12,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tx_en,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_dout,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic        sof,
  output logic        dv,
  output logic [7:0]  dout,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_LEN, S_DATA, S_DISCARD, S_GAP} state_t;

  localparam logic [11:0] LP_MAX = 12'(MAX_LEN);
  localparam logic [11:0] LP_IFG = 12'(IFG);

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_cnt;
  logic        r_first;
  logic        r_dv;
  logic        r_sof;
  logic        r_last;
  logic [7:0]  r_hold;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_err_cnt;

  logic [11:0] w_len;
  logic        w_len_zero;
  logic        w_len_big;
  logic        w_start;
  logic        w_last;
  logic        w_unused;

  assign w_len      = ptr_fifo_dout[11:0];
  assign w_len_zero = (w_len == 12'd0);
  assign w_len_big  = (w_len > LP_MAX);
  assign w_last     = (r_cnt == 12'd1);
  assign w_unused   = ^ptr_fifo_dout[15:12];
  // Gated by rstn so the read strobe is also low while reset is held.
  assign w_start    = (r_state == S_IDLE) && tx_en && !ptr_fifo_empty && rstn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_PTR;
      S_PTR: begin
        if (w_len_zero)     w_next = S_IDLE;
        else if (w_len_big) w_next = S_DISCARD;
        else                w_next = S_DATA;
      end
      S_LEN:     w_next = S_IDLE;
      S_DATA:    if (w_last) w_next = (IFG == 0) ? S_IDLE : S_GAP;
      S_DISCARD: if (w_last) w_next = S_IDLE;
      S_GAP:     if (w_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_fifo_rd  = w_start;
    data_fifo_rd = (r_state == S_DATA) || (r_state == S_DISCARD);
    busy         = (r_state != S_IDLE);
  end

  // r_cnt counts bytes left in DATA/DISCARD, then gap cycles left in GAP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= 12'd0;
      r_first     <= 1'b0;
      r_dv        <= 1'b0;
      r_sof       <= 1'b0;
      r_last      <= 1'b0;
      r_hold      <= 8'd0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      r_dv   <= (r_state == S_DATA);
      r_sof  <= (r_state == S_DATA) && r_first;
      r_last <= (r_state == S_DATA) && w_last;
      if (r_dv) r_hold <= data_fifo_dout;
      case (r_state)
        S_PTR: begin
          r_cnt   <= w_len;
          r_first <= 1'b1;
          if ((w_len_zero || w_len_big) && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
        end
        S_DATA: begin
          r_first <= 1'b0;
          r_cnt   <= w_last ? LP_IFG : (r_cnt - 12'd1);
        end
        S_DISCARD, S_GAP: r_cnt <= r_cnt - 12'd1;
        default: ;
      endcase
      if (r_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign sof       = r_sof;
  assign dv        = r_dv;
  assign dout      = r_dv ? data_fifo_dout : r_hold;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule
